// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// The parity encoding matches the parity_mode pin; code 3 falls outside every enabled mode.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int MIN_DIV = 2;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; the head word is visible while not empty.
// Pushes are refused when full, even if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         push,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with input FIFO, runtime divisor, optional parity and 1/2 stop bits.
// Frame settings are captured when a frame starts, so config edits only affect later frames.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic [1:0]                        parity_mode,
    input  logic                              stop2,
    output logic                              tx,
    output logic                              tx_done,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    state_e                 state_reg;
    logic [DIV_W-1:0]       timer_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [3:0]             bit_idx_reg;
    logic                   par_en_reg;
    logic                   par_bit_reg;
    logic                   stop2_reg;
    logic                   stop_half_reg;
    logic                   tx_reg;
    logic                   tx_done_reg;
    logic                   busy_reg;

    logic [DATA_BITS-1:0]   head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [DIV_W-1:0]       eff_div;
    logic                   bit_end;
    logic                   pre_end;
    logic                   last_stop;

    assign fifo_pop  = (state_reg == IDLE) & ~fifo_empty;
    assign eff_div   = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    assign bit_end   = (timer_reg == div_reg - 1'b1);
    assign pre_end   = (timer_reg == div_reg - DIV_W'(2));
    assign last_stop = ~stop2_reg | stop_half_reg;

    assign s_ready = ~fifo_full;
    assign tx      = tx_reg;
    assign tx_done = tx_done_reg;
    assign busy    = busy_reg;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (s_data),
        .push    (s_valid),
        .pop     (fifo_pop),
        .rd_data (head_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            div_reg       <= DIV_W'(MIN_DIV);
            shift_reg     <= '0;
            bit_idx_reg   <= '0;
            par_en_reg    <= 1'b0;
            par_bit_reg   <= 1'b0;
            stop2_reg     <= 1'b0;
            stop_half_reg <= 1'b0;
            tx_reg        <= 1'b1;
            tx_done_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            timer_reg   <= (state_reg == IDLE || bit_end) ? '0 : timer_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg     <= START;
                        tx_reg        <= 1'b0;
                        busy_reg      <= 1'b1;
                        shift_reg     <= head_data;
                        div_reg       <= eff_div;
                        par_en_reg    <= parity_enabled(parity_mode);
                        par_bit_reg   <= (^head_data) ^ (parity_mode == PAR_ODD);
                        stop2_reg     <= stop2;
                        stop_half_reg <= 1'b0;
                        bit_idx_reg   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg <= DATA;
                        tx_reg    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 4'(DATA_BITS - 1)) begin
                            state_reg <= par_en_reg ? PARITY : STOP;
                            tx_reg    <= par_en_reg ? par_bit_reg : 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end
                end
                STOP: begin
                    // Raised one edge early so the pulse lands in the frame's final clock.
                    if (last_stop && pre_end) begin
                        tx_done_reg <= 1'b1;
                    end
                    if (bit_end) begin
                        if (last_stop) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            stop_half_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
